ysyx_22041752_mdu: RTL and testbench
====================================

# ysyx_22041752_mdu

Iterative RV64M multiply/divide sequencer for the EX stage.
- Accepts one M-extension operation per valid/ready handshake and sequences a single 64-bit shift/add-subtract datapath, one bit per cycle.
- Holds the result until the consumer accepts it.
- Sits beside the single-cycle ALU. The EX stage stalls on `in_ready`/`out_valid` while a mul/div/rem is in flight.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk`.
- `flush` in 1: abort the in-flight operation (pipeline redirect).
- `in_valid` in 1: operation request valid.
- `in_ready` out 1: block can accept a request; high only in IDLE.
- `mdu_op` in 3: RISC-V funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_word` in 1: *W variant; operands taken from bits [31:0], result is the sign-extended 32-bit result.
- `src1` in 64: rs1 value (multiplicand / dividend).
- `src2` in 64: rs2 value (multiplier / divisor).
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer accepts `result`.
- `result` out 64: final result.
- `busy` out 1: state ≠ IDLE.

## Operation
State machine: IDLE → PREP → CALC → FIX → DONE → IDLE.

- **IDLE**
  - Accept when `in_valid & in_ready & ~flush`.
  - Latch `mdu_op`, `op_word`, `src1`, `src2`.
- **PREP**
  - Signed ops (MULH, DIV, REM and their W forms): take the absolute value of each signed operand. MULHSU treats `src2` as unsigned.
  - Record the result sign:
    - mul: XOR of operand signs.
    - div: XOR of operand signs.
    - rem: sign of the dividend.
  - Load the iteration counter N: 64, or 32 if `op_word`.
  - Divisor = 0 → skip CALC, go directly to DONE with:
    - quotient = all ones;
    - remainder = original dividend (sign-extended from bit 31 if `op_word`).
- **CALC** (N cycles)
  - mul: 128-bit shift-add; each cycle the multiplier LSB conditionally adds the multiplicand, then the product shifts right 1.
  - div: restoring division; each cycle shift remainder:quotient left 1, trial-subtract divisor, set quotient bit if no borrow.
- **FIX** (1 cycle)
  - Apply sign negation.
  - Select the result:
    - MUL: product[63:0].
    - MULH*: product[127:64].
    - DIV*: quotient.
    - REM*: remainder.
  - `op_word`: sign-extend bit 31.
- **DONE**
  - `out_valid` = 1; `result` held stable.
  - `out_ready` = 1 → IDLE next cycle.
- Overflow (−2^63 / −1, or −2^31 / −1 for W) needs no special case. Required results: quotient = dividend, remainder = 0.
- `op_word` with `mdu_op` 001–011 executes as MULW.

## Timing
- Reset: state IDLE.
  - `in_ready` = 1; `out_valid` = 0; `busy` = 0.
  - `result` = 0; all internal registers = 0.
- Accept at edge E0:
  - PREP in cycle 1.
  - CALC in cycles 2..N+1.
  - FIX in cycle N+2.
  - `out_valid` first high in cycle N+3: 67 cycles for 64-bit, 35 cycles for W.
- Divide by zero: `out_valid` in cycle 2.
- `in_ready` is low from cycle 1 until the cycle after the DONE handshake. No back-to-back accept in the DONE cycle.
- `out_valid` may be held indefinitely while `out_ready` = 0. `result` must not change while held.
- `flush` in any state: state = IDLE at the next edge; `out_valid` = 0; `result` keeps its last value.
- `flush` together with `in_valid` in IDLE: the request is not accepted.
- `flush` together with the DONE handshake: the flush wins (result dropped).
- `reset` low mid-operation: same as reset, takes effect at the next edge; it overrides `flush`.

## Configuration
- `YSYX_22041752_MDU_MUL_ZERO_SKIP_EN`
  - Defined: a MUL-class op with either masked operand = 0 skips CALC, goes PREP → DONE, and gives `result` = 0 with `out_valid` in cycle 2.
  - Undefined: zero operands take the full N+3 latency. The result is identical in both cases.

## Test plan
- MUL `src1`=7, `src2`=0xFFFFFFFFFFFFFFFD, `out_ready`=1 → `result` 0xFFFFFFFFFFFFFFEB, `out_valid` in cycle 67 only.
- MULHU `src1`=`src2`=0xFFFFFFFFFFFFFFFF → `result` 0xFFFFFFFFFFFFFFFE. MULH with the same operands → 0.
- DIV −7/2 → 0xFFFFFFFFFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFFFFFFFFFF (−1). REMU 7/2 → 1.
- DIVU 5/0 → 0xFFFFFFFFFFFFFFFF in cycle 2. REM 5/0 → 5. DIVW 0x80000000/0xFFFFFFFF → 0xFFFFFFFF80000000 in cycle 35. REMW same operands → 0.
- Accept DIV, assert `flush` in cycle 10 → `in_ready` = 1 in cycle 11, `out_valid` never rises. Then a new MUL 3*4 → 12.
- MUL 2*3 with `out_ready` = 0 for 5 cycles after `out_valid` → `result` stays 6. `reset` low in cycle 20 of a second op → all outputs at reset values next cycle.

Source files
------------

// File: rtl/ysyx_22041752_mdu.sv
// ysyx_22041752_mdu -- iterative RV64M multiply/divide sequencer for EX.
//
// One M-extension op per in_valid/in_ready handshake. A single 64-bit
// shift/add-subtract datapath retires one bit per cycle: shift-add
// multiply or restoring divide. The result is held until out_ready.
//
// Ports:
//   clk, reset (sync, active low)   clock / reset
//   flush                           abort in-flight op, return to IDLE
//   in_valid / in_ready             request handshake (in_ready only in IDLE)
//   mdu_op[2:0], op_word            funct3 encoding, *W variant
//   src1, src2 [63:0]               rs1 / rs2 values
//   out_valid / out_ready           result handshake
//   result [63:0]                   final result, stable while out_valid
//   busy                            state != IDLE
//
// Optional feature macro: YSYX_22041752_MDU_MUL_ZERO_SKIP_EN
//   When defined, a multiply with a zero (masked) operand skips CALC
//   and completes PREP -> DONE with result 0.

module ysyx_22041752_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  mdu_op,
  input  logic        op_word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic        word_q;
  logic [63:0] a_q, b_q;
  logic [63:0] opnd;            // multiplicand (mul) or divisor (div)
  logic [63:0] acc_hi, acc_lo;  // product {hi,lo}, or {remainder,quotient}
  logic [6:0]  cnt;
  logic        neg_res;

  // ---------------- PREP: operand conditioning ----------------
  logic        is_div, sgn_w, s1_sgn, s2_sgn, neg1, neg2;
  logic [63:0] a_ext, b_ext, abs1, abs2, dz_result;
  logic        div_zero, mul_zero, prep_neg;

  always_comb begin
    is_div = op_q[2];
    // Only DIVW/REMW are signed among word ops; word multiplies run as MULW
    // where only the low 32 product bits matter, so they stay unsigned.
    sgn_w  = is_div & ~op_q[0];
    s1_sgn = is_div ? ~op_q[0] : (~word_q & ((op_q == 3'b001) | (op_q == 3'b010)));
    s2_sgn = is_div ? ~op_q[0] : (~word_q & (op_q == 3'b001));
    a_ext  = word_q ? {{32{sgn_w & a_q[31]}}, a_q[31:0]} : a_q;
    b_ext  = word_q ? {{32{sgn_w & b_q[31]}}, b_q[31:0]} : b_q;
    neg1   = s1_sgn & a_ext[63];
    neg2   = s2_sgn & b_ext[63];
    abs1   = neg1 ? (64'd0 - a_ext) : a_ext;
    abs2   = neg2 ? (64'd0 - b_ext) : b_ext;
    // REM* takes the dividend sign; everything else the XOR of signs.
    prep_neg = (is_div & op_q[1]) ? neg1 : (neg1 ^ neg2);
    div_zero = is_div & (b_ext == 64'd0);
    mul_zero = ~is_div & ((a_ext == 64'd0) | (b_ext == 64'd0));
    // Divide by zero: quotient all ones, remainder the original dividend.
    dz_result = op_q[1] ? (word_q ? {{32{a_q[31]}}, a_q[31:0]} : a_q)
                        : {64{1'b1}};
  end

  // ---------------- CALC: one bit per cycle ----------------
  logic [64:0] mul_sum;
  logic [64:0] div_sh;
  logic        div_ok;
  logic [63:0] div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 65'd0);
    div_sh   = {acc_hi, acc_lo[63]};
    div_ok   = (div_sh >= {1'b0, opnd});
    // When the trial subtract succeeds the difference is below the divisor,
    // so the low 64 bits carry the whole remainder.
    div_diff = div_sh[63:0] - opnd;
  end

  // ---------------- FIX: sign and result selection ----------------
  logic [127:0] prod_s;
  logic [63:0]  mul_lo, quo_s, rem_s, div_r, fix_res;

  always_comb begin
    prod_s = neg_res ? (128'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    // After 32 iterations the 64-bit word product sits at bits [95:32].
    mul_lo = word_q ? {{32{prod_s[63]}}, prod_s[63:32]} : prod_s[63:0];
    quo_s  = neg_res ? (64'd0 - acc_lo) : acc_lo;
    rem_s  = neg_res ? (64'd0 - acc_hi) : acc_hi;
    div_r  = op_q[1] ? rem_s : quo_s;
    if (is_div)
      fix_res = word_q ? {{32{div_r[31]}}, div_r[31:0]} : div_r;
    else if (word_q || op_q == 3'b000)
      fix_res = mul_lo;
    else
      fix_res = prod_s[127:64];
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= 64'd0;
      op_q      <= 3'd0;
      word_q    <= 1'b0;
      a_q       <= 64'd0;
      b_q       <= 64'd0;
      opnd      <= 64'd0;
      acc_hi    <= 64'd0;
      acc_lo    <= 64'd0;
      cnt       <= 7'd0;
      neg_res   <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= mdu_op;
            word_q   <= op_word;
            a_q      <= src1;
            b_q      <= src2;
            state    <= S_PREP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_PREP: begin
          neg_res <= prep_neg;
          cnt     <= word_q ? 7'd32 : 7'd64;
          if (div_zero) begin
            result    <= dz_result;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
`ifdef YSYX_22041752_MDU_MUL_ZERO_SKIP_EN
          else if (mul_zero) begin
            result    <= 64'd0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
`endif
          else begin
            opnd  <= is_div ? abs2 : abs1;
            state <= S_CALC;
            if (is_div) begin
              // Word dividend goes in the upper half so its MSB shifts out first.
              acc_hi <= 64'd0;
              acc_lo <= word_q ? {abs1[31:0], 32'd0} : abs1;
            end else begin
              acc_hi <= 64'd0;
              acc_lo <= abs2;
            end
          end
        end
        S_CALC: begin
          if (is_div) begin
            acc_hi <= div_ok ? div_diff : div_sh[63:0];
            acc_lo <= {acc_lo[62:0], div_ok};
          end else begin
            acc_hi <= mul_sum[64:1];
            acc_lo <= {mul_sum[0], acc_lo[63:1]};
          end
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= S_FIX;
        end
        S_FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // mul_zero is only consumed when the zero-skip feature is compiled in.
  logic unused_ok;
  assign unused_ok = mul_zero;

endmodule

// File: tb/tb_ysyx_22041752_mdu.sv
// Self-checking bench for ysyx_22041752_mdu: table of vectors driven through
// a scoreboard queue, plus hand-written flush / hold / reset sequences.

module tb_ysyx_22041752_mdu;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, op_word, out_ready;
  logic [2:0]  mdu_op;
  logic [63:0] src1, src2;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;

  ysyx_22041752_mdu dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .mdu_op(mdu_op), .op_word(op_word),
    .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef YSYX_22041752_MDU_MUL_ZERO_SKIP_EN
  localparam int ZL = 2;
`else
  localparam int ZL = 67;
`endif

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs [18];
  logic [63:0] sb [$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, check latency and result.
  task automatic run_op(input string name, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int cyc;
    bit got;
    chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    mdu_op = op; op_word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(exp);
    cyc = 1; got = 0;
    while (!got && cyc < 200) begin
      if (out_valid) got = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no out_valid required=out_valid", name);
      void'(sb.pop_front());
    end else begin
      chk({name, "_lat"}, 64'(cyc), 64'(lat));
      chk({name, "_res"}, result, sb.pop_front());
      if (out_ready) begin
        @(posedge clk); #1;
        chk({name, "_vld_drop"}, {63'd0, out_valid}, 64'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] last;
    int bad;
    //            op      w     a                        b                        exp                      lat
    vecs[0]  = '{3'b000, 1'b0, 64'd7,                   64'hFFFFFFFFFFFFFFFD,    64'hFFFFFFFFFFFFFFEB,    67};
    vecs[1]  = '{3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFF,    64'hFFFFFFFFFFFFFFFF,    64'hFFFFFFFFFFFFFFFE,    67};
    vecs[2]  = '{3'b001, 1'b0, 64'hFFFFFFFFFFFFFFFF,    64'hFFFFFFFFFFFFFFFF,    64'd0,                   67};
    vecs[3]  = '{3'b100, 1'b0, 64'hFFFFFFFFFFFFFFF9,    64'd2,                   64'hFFFFFFFFFFFFFFFD,    67};
    vecs[4]  = '{3'b110, 1'b0, 64'hFFFFFFFFFFFFFFF9,    64'd2,                   64'hFFFFFFFFFFFFFFFF,    67};
    vecs[5]  = '{3'b111, 1'b0, 64'd7,                   64'd2,                   64'd1,                   67};
    vecs[6]  = '{3'b101, 1'b0, 64'd5,                   64'd0,                   64'hFFFFFFFFFFFFFFFF,    2};
    vecs[7]  = '{3'b110, 1'b0, 64'd5,                   64'd0,                   64'd5,                   2};
    vecs[8]  = '{3'b100, 1'b1, 64'h0000000080000000,    64'h00000000FFFFFFFF,    64'hFFFFFFFF80000000,    35};
    vecs[9]  = '{3'b110, 1'b1, 64'h0000000080000000,    64'h00000000FFFFFFFF,    64'd0,                   35};
    vecs[10] = '{3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFF,    64'd2,                   64'hFFFFFFFFFFFFFFFF,    67};
    vecs[11] = '{3'b001, 1'b1, 64'h0000000040000000,    64'd2,                   64'hFFFFFFFF80000000,    35};
    vecs[12] = '{3'b100, 1'b0, 64'h8000000000000000,    64'hFFFFFFFFFFFFFFFF,    64'h8000000000000000,    67};
    vecs[13] = '{3'b110, 1'b0, 64'h8000000000000000,    64'hFFFFFFFFFFFFFFFF,    64'd0,                   67};
    vecs[14] = '{3'b101, 1'b1, 64'h12345678FFFFFFFF,    64'd3,                   64'h0000000055555555,    35};
    vecs[15] = '{3'b000, 1'b0, 64'd0,                   64'd5,                   64'd0,                   ZL};
    vecs[16] = '{3'b111, 1'b1, 64'h0000000080000005,    64'hABCD000000000000,    64'hFFFFFFFF80000005,    2};
    vecs[17] = '{3'b011, 1'b0, 64'h123456789ABCDEF0,    64'h0FEDCBA987654321,    64'h0121FA00AD77D742,    67};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; op_word = 1'b0;
    out_ready = 1'b1; mdu_op = 3'd0; src1 = 64'd0; src2 = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", result, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].w, vecs[i].a,
             vecs[i].b, vecs[i].exp, vecs[i].lat);

    // flush together with in_valid in IDLE: not accepted
    mdu_op = 3'b000; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);
    chk("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);

    // DIV flushed in cycle 10
    last = result;
    mdu_op = 3'b100; op_word = 1'b0; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid) bad++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 64'(bad), 64'd0);
    chk("flush_result_kept", result, last);
    run_op("post_flush_mul", 3'b000, 1'b0, 64'd3, 64'd4, 64'd12, 67);

    // result held while out_ready is low
    out_ready = 1'b0;
    run_op("hold_mul", 3'b000, 1'b0, 64'd2, 64'd3, 64'd6, 67);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (!out_valid || result !== 64'd6) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", {63'd0, out_valid}, 64'd0);

    // reset low in cycle 20 of a second op
    mdu_op = 3'b100; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_result", result, 64'd0);
    reset = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst_div", 3'b100, 1'b0, 64'd100, 64'd7, 64'd14, 67);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
